// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch prefetch unit.
package fetch_pkg;

    // One decoded-side entry: the instruction word and the PC it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Sequential fetch increment in bytes.
    localparam logic [31:0] PC_STEP = 32'd4;

    // Pointer width for a power-of-two queue of the given depth.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with push/pop/flush and full/empty/count.
// Used both for the instruction data buffer and for the in-order PC tag queue.
// A pop and a push in the same cycle on a full queue both take effect.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  T                      wr_data,
    output T                      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [ptr_w(DEPTH):0] count
);
    localparam int PW = ptr_w(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    T              mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy update; flush and reset both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: fetch-side producer of the F->D interface.
// Issues sequential in-order requests to a variable-latency instruction port,
// buffers returned words and presents {InstrF, PCF, PCPlus4F} to decode.
// Redirects flush the buffer and drop responses still in flight.
// Optional build macro FETCH_BYPASS_EN: a response arriving while the buffer
// is empty is presented combinationally in the same cycle.
//
// Handshakes: a request transfers on a rising edge where IReqValid and
// IReqReady are both high; IReqValid never depends on IReqReady. Responses
// carry no ready: each IRspValid cycle returns exactly one word, in request
// order. Decode consumes the presented entry on any edge where InstrValidF is
// high and StallD is low; while StallD is high the outputs do not change.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCRedirectE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    output logic        IReqValid,
    input  logic        IReqReady,
    output logic [31:0] IReqAddr,
    input  logic        IRspValid,
    input  logic [31:0] IRspData,
    output logic        InstrValidF,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F
);
    localparam int CW = ptr_w(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_cnt;
    logic [CW:0]   inflight;

    logic          req_fire;
    logic          rsp_fire;
    logic          rsp_keep;

    logic [31:0]   tag_head;
    logic          tag_full;
    logic          tag_empty;
    logic [CW-1:0] tag_count;

    fetch_entry_t  data_in;
    fetch_entry_t  data_head;
    fetch_entry_t  out_entry;
    logic          data_push;
    logic          data_pop;
    logic          data_full;
    logic          data_empty;
    logic [CW-1:0] data_count;
    logic          out_valid;

    // Buffered entries plus requests in flight never exceed DEPTH, so neither
    // queue can overflow.
    assign inflight  = {1'b0, data_count} + {1'b0, outstanding};
    assign IReqValid = ~rst & ~PCRedirectE & (inflight < DEPTH_W);
    assign IReqAddr  = fetch_pc;
    assign req_fire  = IReqValid & IReqReady;

    // A response with nothing outstanding is ignored entirely.
    assign rsp_fire  = IRspValid & (outstanding != '0) & ~rst;
    assign rsp_keep  = rsp_fire & (drop_cnt == '0);

    // Net change of the outstanding count for this cycle.
    always_comb begin
        outstanding_next = outstanding;
        if (req_fire && !rsp_fire) begin
            outstanding_next = outstanding + CW'(1);
        end else if (!req_fire && rsp_fire) begin
            outstanding_next = outstanding - CW'(1);
        end
    end

    // Fetch PC and counters; a redirect overrides the normal updates and marks
    // every request still in flight as stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (PCRedirectE) begin
                fetch_pc <= PCTargetE;
                drop_cnt <= outstanding_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (rsp_fire && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    // PCs of accepted requests, popped in order as responses return.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (logic [31:0])
    ) u_tag_q (
        .clk     (clk),
        .rst     (rst),
        .push    (req_fire),
        .pop     (rsp_fire),
        .flush   (1'b0),
        .wr_data (fetch_pc),
        .rd_data (tag_head),
        .full    (tag_full),
        .empty   (tag_empty),
        .count   (tag_count)
    );

    assign data_in  = '{pc: tag_head, instr: IRspData};
    assign data_pop = ~data_empty & ~StallD;

`ifdef FETCH_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = data_empty & rsp_keep;
    assign data_push  = rsp_keep & ~(bypass_hit & ~StallD);
    assign out_valid  = ~data_empty | bypass_hit;
    assign out_entry  = data_empty ? data_in : data_head;
`else
    assign data_push  = rsp_keep;
    assign out_valid  = ~data_empty;
    assign out_entry  = data_head;
`endif

    // Instruction buffer; a redirect flushes it, discarding any same-cycle pop.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_data_q (
        .clk     (clk),
        .rst     (rst),
        .push    (data_push),
        .pop     (data_pop),
        .flush   (PCRedirectE),
        .wr_data (data_in),
        .rd_data (data_head),
        .full    (data_full),
        .empty   (data_empty),
        .count   (data_count)
    );

    assign InstrValidF = out_valid;
    assign InstrF      = out_valid ? out_entry.instr : '0;
    assign PCF         = out_valid ? out_entry.pc : '0;
    assign PCPlus4F    = out_valid ? (out_entry.pc + PC_STEP) : '0;

    a_rsp_needs_req: assert property (@(posedge clk) disable iff (rst)
        IRspValid |-> (outstanding != '0));
    a_tag_tracks_outstanding: assert property (@(posedge clk) disable iff (rst)
        (tag_count == outstanding) && (tag_empty == (outstanding == '0)));
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (rst)
        req_fire |-> (!tag_full || rsp_fire));
    a_data_no_overflow: assert property (@(posedge clk) disable iff (rst)
        data_push |-> (!data_full || data_pop));

endmodule
